// File: rtl/wash_machine_model_if.sv
// Plant-side bus bundle for the washing-machine model: actuator commands and raw
// operator inputs in, the 9-bit sensor word, level display and fault flag out.
interface wash_machine_model_if;
  logic [5:0] act;
  logic       btn_start;
  logic       btn_restart;
  logic       sw_extra_rinse;
  logic       sw_hot;
  logic       sw_warm;
  logic       sw_cold;
  logic [8:0] bus_in;
  logic [3:0] level;
  logic       fault;

  modport master (
    output act, btn_start, btn_restart, sw_extra_rinse, sw_hot, sw_warm, sw_cold,
    input  bus_in, level, fault
  );

  modport slave (
    input  act, btn_start, btn_restart, sw_extra_rinse, sw_hot, sw_warm, sw_cold,
    output bus_in, level, fault
  );
endinterface

// File: rtl/wash_machine_model.sv
// Cycle-accurate washing-machine plant: tick generator, water level, button debouncers,
// temperature/rinse sampling. Define WASH_MODEL_FAULT_EN to build the sticky misuse flag.
module wash_machine_model #(
  parameter int LEVEL_MAX = 15,
  parameter int TICK_DIV  = 50,
  parameter int DEBOUNCE  = 4
) (
  input logic                 clock,
  input logic                 reset,
  wash_machine_model_if.slave plant
);
  localparam int             DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [4:0]     LMAX     = 5'(LEVEL_MAX);

  typedef enum logic [1:0] {DB_IDLE, DB_ARM_HI, DB_PRESSED, DB_ARM_LO} db_state_t;

  logic [DW-1:0] div_cnt;
  logic          wrap, tick_clk, tick;
  logic [3:0]    level_q, level_nx;
  logic [1:0]    n_valve;
  logic [4:0]    lvl_sum;
  logic [2:0]    temp;
  logic          extra;
  logic [1:0]    raw, pulse;
  logic          unused_act;

  // tick is registered so it coincides with the first high cycle of bus_in[2]
  assign wrap = (div_cnt == DIV_LAST);
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_clk <= 1'b0;
      tick     <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) tick_clk <= ~tick_clk;
      tick <= wrap & ~tick_clk;
    end
  end

  always_comb begin
    n_valve  = {1'b0, plant.act[1]} + {1'b0, plant.act[0]};
    lvl_sum  = {1'b0, level_q} + {3'b000, n_valve};
    level_nx = level_q;
    if (!plant.act[3])
      level_nx = (lvl_sum > LMAX) ? LMAX[3:0] : lvl_sum[3:0];
    else if (n_valve == 2'd0 && level_q != 4'd0)
      level_nx = level_q - 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset)     level_q <= 4'd0;
    else if (tick) level_q <= level_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      temp  <= 3'b100;
      extra <= 1'b0;
    end else begin
      extra <= plant.sw_extra_rinse;
      if (plant.sw_hot)       temp <= 3'b001;
      else if (plant.sw_warm) temp <= 3'b010;
      else                    temp <= 3'b100;
    end
  end

  // index 1 = start, 0 = restart
  assign raw = {plant.btn_start, plant.btn_restart};

  for (genvar b = 0; b < 2; b++) begin : g_db
    db_state_t  state, state_nx;
    logic [3:0] cnt;
    logic       hit, cnt_clr, cnt_inc, pulse_nx, pulse_q;

    assign hit = (cnt == 4'(DEBOUNCE - 1));

    always_ff @(posedge clock) begin
      if (reset) begin
        state   <= DB_IDLE;
        cnt     <= 4'd0;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_nx;
        pulse_q <= pulse_nx;
        if (cnt_clr)      cnt <= 4'd0;
        else if (cnt_inc) cnt <= cnt + 4'd1;
      end
    end

    always_comb begin
      state_nx = state;
      case (state)
        DB_IDLE:    if (raw[b]) state_nx = DB_ARM_HI;
        DB_ARM_HI:  if (!raw[b]) state_nx = DB_IDLE;    else if (hit) state_nx = DB_PRESSED;
        DB_PRESSED: if (!raw[b]) state_nx = DB_ARM_LO;
        DB_ARM_LO:  if (raw[b])  state_nx = DB_PRESSED; else if (hit) state_nx = DB_IDLE;
        default:    state_nx = DB_IDLE;
      endcase
    end

    // counter restarts on every state change, so it only measures the current run
    always_comb begin
      cnt_clr  = (state_nx != state);
      cnt_inc  = (state == DB_ARM_HI && raw[b]) || (state == DB_ARM_LO && !raw[b]);
      pulse_nx = (state == DB_ARM_HI) && (state_nx == DB_PRESSED);
    end

    assign pulse[b] = pulse_q;
  end

`ifdef WASH_MODEL_FAULT_EN
  logic fault_q, fault_set;
  // a same-cycle misuse outranks the restart clear
  assign fault_set = (plant.act[4] && level_q != 4'd0) ||
                     (plant.act[3] && n_valve != 2'd0) ||
                     (tick && n_valve != 2'd0 && level_q == LMAX[3:0]);
  always_ff @(posedge clock) begin
    if (reset)          fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
    else if (pulse[0])  fault_q <= 1'b0;
  end
  assign plant.fault = fault_q;
`else
  assign plant.fault = 1'b0;
`endif

  assign unused_act = ^{plant.act[5], plant.act[4], plant.act[2]};

  assign plant.bus_in = {pulse[1], pulse[0], temp, extra, tick_clk,
                         (level_q == LMAX[3:0]), (level_q == 4'd0)};
  assign plant.level  = level_q;
endmodule
